// File: rtl/ip_tx_framer.sv
// rtl/ip_tx_framer.sv - byte FIFO to IP header + payload stream framer; IP_TX_LEN_CHECK_EN enables the LEN filter
module ip_tx_framer #(
    parameter int MAX_PAYLOAD = 1480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_empty_n,
    output logic        din_read,
    input  logic [31:0] local_ip,
    output logic        tx_ip_hdr_valid,
    input  logic        tx_ip_hdr_ready,
    output logic [5:0]  tx_ip_dscp,
    output logic [1:0]  tx_ip_ecn,
    output logic [15:0] tx_ip_length,
    output logic [7:0]  tx_ip_ttl,
    output logic [7:0]  tx_ip_protocol,
    output logic [31:0] tx_ip_source_ip,
    output logic [31:0] tx_ip_dest_ip,
    output logic [7:0]  tx_ip_payload_axis_tdata,
    output logic        tx_ip_payload_axis_tvalid,
    input  logic        tx_ip_payload_axis_tready,
    output logic        tx_ip_payload_axis_tlast,
    output logic        busy
`ifdef IP_TX_LEN_CHECK_EN
    ,
    output logic [15:0] drop_count
`endif
);

    if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 65535) begin : g_max_payload_range
        $error("MAX_PAYLOAD must fit the 16-bit LEN field");
    end

    typedef enum logic [1:0] {
        HDR      = 2'd0,
        SEND_HDR = 2'd1,
        PAYLOAD  = 2'd2
`ifdef IP_TX_LEN_CHECK_EN
        ,
        DRAIN    = 2'd3
`endif
    } state_t;

    state_t      state, state_n;
    logic [2:0]  byte_cnt;
    logic [55:0] pre;
    logic [31:0] hdr_dest;
    logic [31:0] hdr_src;
    logic [15:0] hdr_len;
    logic [7:0]  hdr_proto;
    logic [7:0]  hdr_ttl;
    logic [15:0] remaining;
    logic        rst_q;
    logic        quiet;

    logic        pop;
    logic        hdr_v;
    logic        pay_v;
    logic        pay_last;
    logic [63:0] pre_word;
    logic [15:0] frame_len;
    logic        last_pre_byte;

    // The 8th byte is still on din when the frame decision is made, so look at it combined with the shift register.
    assign pre_word      = {pre, din};
    assign frame_len     = pre_word[31:16];
    assign last_pre_byte = (byte_cnt == 3'd7);
    assign quiet         = rst | rst_q;

`ifdef IP_TX_LEN_CHECK_EN
    localparam logic [16:0] MAX_LEN = 17'(MAX_PAYLOAD);
    logic len_bad;
    assign len_bad = (frame_len == 16'd0) || ({1'b0, frame_len} > MAX_LEN);
`endif

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        hdr_v    = 1'b0;
        pay_v    = 1'b0;
        pay_last = 1'b0;
        // The cycle after reset is kept silent even if the FIFO already holds data.
        if (!rst_q) begin
            case (state)
                HDR: begin
                    pop = din_empty_n;
                    if (din_empty_n && last_pre_byte) begin
`ifdef IP_TX_LEN_CHECK_EN
                        state_n = len_bad ? DRAIN : SEND_HDR;
`else
                        state_n = SEND_HDR;
`endif
                    end
                end
                SEND_HDR: begin
                    hdr_v = 1'b1;
                    if (tx_ip_hdr_ready)
                        state_n = (hdr_len != 16'd0) ? PAYLOAD : HDR;
                end
                PAYLOAD: begin
                    pay_v    = din_empty_n;
                    pay_last = (remaining == 16'd1);
                    pop      = pay_v && tx_ip_payload_axis_tready;
                    if (pop && pay_last)
                        state_n = HDR;
                end
`ifdef IP_TX_LEN_CHECK_EN
                DRAIN: begin
                    if (remaining == 16'd0) begin
                        state_n = HDR;
                    end else begin
                        pop = din_empty_n;
                        if (din_empty_n && remaining == 16'd1)
                            state_n = HDR;
                    end
                end
`endif
                default: state_n = HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state     <= HDR;
            byte_cnt  <= 3'd0;
            pre       <= '0;
            hdr_dest  <= '0;
            hdr_src   <= '0;
            hdr_len   <= '0;
            hdr_proto <= '0;
            hdr_ttl   <= '0;
            remaining <= '0;
`ifdef IP_TX_LEN_CHECK_EN
            drop_count <= '0;
`endif
        end else begin
            state <= state_n;
            if (state == HDR && pop) begin
                byte_cnt <= byte_cnt + 3'd1;
                pre      <= pre_word[55:0];
                if (last_pre_byte) begin
                    hdr_dest  <= pre_word[63:32];
                    hdr_len   <= frame_len;
                    hdr_proto <= pre_word[15:8];
                    hdr_ttl   <= pre_word[7:0];
                    hdr_src   <= local_ip;
                    remaining <= frame_len;
`ifdef IP_TX_LEN_CHECK_EN
                    if (len_bad && drop_count != 16'hFFFF)
                        drop_count <= drop_count + 16'd1;
`endif
                end
            end
            // Only PAYLOAD and DRAIN pop outside HDR.
            if (state != HDR && pop)
                remaining <= remaining - 16'd1;
        end
    end

    assign din_read                  = pop & ~rst;
    assign tx_ip_hdr_valid           = hdr_v & ~rst;
    assign tx_ip_dscp                = 6'd0;
    assign tx_ip_ecn                 = 2'd0;
    assign tx_ip_length              = quiet ? 16'd0 : hdr_len + 16'd20;
    assign tx_ip_ttl                 = quiet ? 8'd0  : hdr_ttl;
    assign tx_ip_protocol            = quiet ? 8'd0  : hdr_proto;
    assign tx_ip_source_ip           = quiet ? 32'd0 : hdr_src;
    assign tx_ip_dest_ip             = quiet ? 32'd0 : hdr_dest;
    assign tx_ip_payload_axis_tdata  = din;
    assign tx_ip_payload_axis_tvalid = pay_v & ~rst;
    assign tx_ip_payload_axis_tlast  = pay_last & ~rst;
    assign busy                      = ~quiet & ~(state == HDR && byte_cnt == 3'd0);

endmodule

// File: tb/tb_ip_tx_framer.sv
// tb/tb_ip_tx_framer.sv - randomized scoreboard bench for ip_tx_framer
`timescale 1ns/1ps
module tb_ip_tx_framer;
    localparam int MAXP = 1480;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        din_empty_n = 1'b0;
    logic        din_read;
    logic [31:0] local_ip = 32'h0;
    logic        hdr_valid;
    logic        hdr_ready = 1'b0;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] length;
    logic [7:0]  ttl, proto;
    logic [31:0] src, dst;
    logic [7:0]  tdata;
    logic        tvalid, tlast, busy;
    logic        tready = 1'b0;
`ifdef IP_TX_LEN_CHECK_EN
    logic [15:0] drop_count;
`endif

    ip_tx_framer #(.MAX_PAYLOAD(MAXP)) dut (
        .clk(clk), .rst(rst),
        .din(din), .din_empty_n(din_empty_n), .din_read(din_read),
        .local_ip(local_ip),
        .tx_ip_hdr_valid(hdr_valid), .tx_ip_hdr_ready(hdr_ready),
        .tx_ip_dscp(dscp), .tx_ip_ecn(ecn), .tx_ip_length(length),
        .tx_ip_ttl(ttl), .tx_ip_protocol(proto),
        .tx_ip_source_ip(src), .tx_ip_dest_ip(dst),
        .tx_ip_payload_axis_tdata(tdata), .tx_ip_payload_axis_tvalid(tvalid),
        .tx_ip_payload_axis_tready(tready), .tx_ip_payload_axis_tlast(tlast),
        .busy(busy)
`ifdef IP_TX_LEN_CHECK_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dst;
        logic [31:0] src;
        logic [15:0] length;
        logic [7:0]  proto;
        logic [7:0]  ttl;
    } hdr_t;

    hdr_t       exp_hdr[$];
    logic [8:0] exp_beat[$];
    logic [7:0] fifo[$];
    logic [7:0] pay[$];
    hdr_t       mon_h;
    logic [8:0] mon_b;

    int compared = 0, mismatched = 0;
    int beats = 0, pops = 0, exp_drops = 0;
    int hdr_mode = 0, tr_mode = 0;
    bit gaps = 1'b0, chk_b2b = 1'b0, after_tlast = 1'b0, pop_pend = 1'b0;

    logic [108:0] outs;
    assign outs = {din_read, hdr_valid, tvalid, tlast, busy, dscp, ecn, length, ttl, proto, src, dst};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_din();
        din_empty_n = (fifo.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        din = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // Monitor: scoreboard pops on every header / payload handshake.
    always @(negedge clk) begin
        if (hdr_valid && hdr_ready) begin
            if (exp_hdr.size() == 0) begin
                check("unexpected_hdr", 1, 0);
            end else begin
                mon_h = exp_hdr.pop_front();
                check("hdr_fields", {dst, src, length, proto, ttl}, mon_h);
                check("hdr_dscp_ecn", {dscp, ecn}, 0);
            end
        end
        if (hdr_valid)
            check("no_pop_in_send_hdr", din_read, 0);
        if (chk_b2b && after_tlast && din_empty_n)
            check("b2b_first_pop", din_read, 1);
        after_tlast = 1'b0;
        if (tvalid && tready) begin
            beats++;
            if (exp_beat.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                mon_b = exp_beat.pop_front();
                check("beat_last_data", {tlast, tdata}, mon_b);
            end
            after_tlast = tlast;
        end
        if (din_read && !din_empty_n)
            check("pop_when_empty", 1, 0);
        pop_pend = din_read && din_empty_n;
        if (pop_pend)
            pops++;
    end

    // FIFO model and ready generation, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (pop_pend && fifo.size() > 0)
            void'(fifo.pop_front());
        pop_pend = 1'b0;
        case (hdr_mode)
            0:       hdr_ready = 1'b1;
            1:       hdr_ready = 1'($urandom_range(0, 1));
            default: hdr_ready = 1'b0;
        endcase
        case (tr_mode)
            0:       tready = 1'b1;
            1:       tready = 1'($urandom_range(0, 1));
            default: tready = ~tready;
        endcase
        drive_din();
    end

    // Reference model: a frame either produces one header plus LEN beats, or is dropped.
    task automatic push_frame(input logic [31:0] d, input int len, input logic [7:0] pr,
                              input logic [7:0] tt, input bit fill_rand);
        bit bad;
        logic [15:0] l16;
        l16 = 16'(len);
        if (fill_rand) begin
            pay.delete();
            for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
        end
        fifo.push_back(d[31:24]); fifo.push_back(d[23:16]);
        fifo.push_back(d[15:8]);  fifo.push_back(d[7:0]);
        fifo.push_back(l16[15:8]); fifo.push_back(l16[7:0]);
        fifo.push_back(pr); fifo.push_back(tt);
`ifdef IP_TX_LEN_CHECK_EN
        bad = (len == 0) || (len > MAXP);
`else
        bad = 1'b0;
`endif
        if (bad) begin
            exp_drops++;
        end else begin
            exp_hdr.push_back({d, local_ip, 16'(len + 20), pr, tt});
            for (int i = 0; i < len; i++) exp_beat.push_back({i == len - 1, pay[i]});
        end
        for (int i = 0; i < len; i++) fifo.push_back(pay[i]);
        drive_din();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((fifo.size() > 0 || exp_hdr.size() > 0 || exp_beat.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        check({"drained_", name}, n < budget, 1);
    endtask

    initial begin
        int b0, p0, n;
        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        check("reset_outputs", outs, 0);
`ifdef IP_TX_LEN_CHECK_EN
        check("reset_drop_count", drop_count, 0);
`endif
        step();
        rst = 1'b0;
        local_ip = 32'hC0A80164;
        pay = '{8'hAA, 8'hBB, 8'hCC};
        push_frame(32'hC0A80102, 3, 8'h11, 8'h40, 1'b0);
        @(negedge clk);
        check("first_cycle_after_rst", outs, 0);
        wait_idle("basic", 200);

        // Header back-pressure for five cycles.
        hdr_mode = 2;
        push_frame(32'hC0A80102, 3, 8'h11, 8'h40, 1'b0);
        n = 0;
        while (!hdr_valid && n < 50) begin step(); n++; end
        check("hdr_valid_seen", hdr_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hdr_hold_valid", hdr_valid, 1);
            check("hdr_hold_fields", {dst, src, length, proto, ttl},
                  {32'hC0A80102, 32'hC0A80164, 16'd23, 8'h11, 8'h40});
            check("hdr_hold_no_pop", din_read, 0);
        end
        step();
        hdr_mode = 0;
        wait_idle("hdr_stall", 200);

        // tready toggling over a 4-byte payload.
        tr_mode = 2;
        b0 = beats; p0 = pops;
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_frame(32'h0A000001, 4, 8'h06, 8'h80, 1'b0);
        wait_idle("toggle", 200);
        check("toggle_beats", beats - b0, 4);
        check("toggle_pops", pops - p0, 12);
        tr_mode = 0;

        // Two frames queued back to back.
        chk_b2b = 1'b1;
        push_frame(32'h0A000002, 3, 8'h11, 8'h01, 1'b1);
        push_frame(32'h0A000003, 5, 8'h11, 8'h02, 1'b1);
        wait_idle("b2b", 200);
        chk_b2b = 1'b0;

        // Reset after two of five payload bytes.
        b0 = beats;
        push_frame(32'h0A000004, 5, 8'h11, 8'h03, 1'b1);
        n = 0;
        while (beats - b0 < 2 && n < 100) begin step(); n++; end
        check("mid_frame_beats", beats - b0, 2);
        rst = 1'b1;
        fifo.delete(); exp_hdr.delete(); exp_beat.delete();
        drive_din();
        @(negedge clk);
        check("rst_mid_frame_outputs", outs, 0);
        step();
        rst = 1'b0;
        push_frame(32'h0A000005, 6, 8'h11, 8'h04, 1'b1);
        @(negedge clk);
        check("post_rst_cycle_outputs", outs, 0);
        wait_idle("after_rst", 300);

`ifdef IP_TX_LEN_CHECK_EN
        p0 = pops;
        push_frame(32'h0A000006, 1481, 8'h11, 8'h05, 1'b1);
        push_frame(32'h0A000007, 4, 8'h11, 8'h06, 1'b1);
        wait_idle("oversize", 3000);
        check("oversize_pops", pops - p0, 8 + 1481 + 8 + 4);
        check("oversize_drop_count", drop_count, exp_drops);
`endif

        // Randomized batches with FIFO gaps and random back-pressure.
        gaps = 1'b1;
        for (int b = 0; b < 6; b++) begin
            local_ip = $urandom;
            hdr_mode = $urandom_range(0, 1);
            tr_mode  = $urandom_range(0, 1);
            for (int k = 0; k < 4; k++)
                push_frame($urandom, $urandom_range(0, 24), 8'($urandom), 8'($urandom), 1'b1);
            wait_idle("random", 3000);
        end
`ifdef IP_TX_LEN_CHECK_EN
        check("final_drop_count", drop_count, exp_drops);
`endif
        check("final_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ip_tx_framer.md
IP_TX_FRAMER -- requirements
Module: ip_tx_framer

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 1480, the largest payload length in bytes that is accepted.
REQ-002 SHALL have port clk  in  1  the single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports din  in  8, din_empty_n  in  1, din_read  out  1 (first-word-fall-through byte FIFO read side).
- din is valid whenever din_empty_n=1.
- din_read=1 pops that byte in the same cycle.
REQ-005 SHALL have port local_ip  in  32  source IP address, sampled when the header is captured.
REQ-006 SHALL have ports tx_ip_hdr_valid  out  1 and tx_ip_hdr_ready  in  1.
REQ-007 SHALL have header field outputs: tx_ip_dscp  out  6, tx_ip_ecn  out  2, tx_ip_length  out  16, tx_ip_ttl  out  8, tx_ip_protocol  out  8, tx_ip_source_ip  out  32, tx_ip_dest_ip  out  32.
REQ-008 SHALL have AXI-stream payload ports: tx_ip_payload_axis_tdata  out  8, tx_ip_payload_axis_tvalid  out  1, tx_ip_payload_axis_tready  in  1, tx_ip_payload_axis_tlast  out  1.
REQ-009 SHALL have port busy  out  1, high in every state except HDR when the byte count is 0.

Function
REQ-010 SHALL parse each input frame as an 8-byte preamble followed by LEN payload bytes.
- Preamble, big-endian: dest_ip[4], LEN[2], protocol[1], ttl[1].
REQ-011 SHALL implement the states HDR, SEND_HDR, PAYLOAD and DRAIN.
REQ-012 In HDR, SHALL assert din_read whenever din_empty_n=1, shifting each byte into the preamble register and counting it with a 3-bit counter.
REQ-013 After the 8th preamble byte is popped, SHALL enter SEND_HDR (or DRAIN, per REQ-024) on the next cycle.
- tx_ip_hdr_valid rises exactly 1 cycle after the 8th pop.
REQ-014 In SEND_HDR, SHALL hold tx_ip_hdr_valid=1 with all header fields stable until tx_ip_hdr_ready=1.
- Header fields: dscp=0, ecn=0, length=LEN+20 (16-bit, wraps modulo 2^16), ttl, protocol, source_ip=local_ip captured on the 8th pop, dest_ip.
REQ-015 On the SEND_HDR handshake, SHALL go to PAYLOAD if LEN>0, otherwise to HDR.
REQ-016 In PAYLOAD, SHALL drive the payload stream directly from the FIFO.
- tvalid = din_empty_n; tdata = din; din_read = tvalid AND tready.
- No added latency and no bubbles while data and ready are both present.
REQ-017 SHALL keep a 16-bit remaining counter loaded with LEN, decremented on each payload beat.
- tlast = 1 when remaining = 1.
- After the tlast beat, return to HDR.
REQ-018 SHALL never assert din_read in SEND_HDR.
REQ-019 SHALL accept a back-to-back next preamble starting in the cycle after tlast, with no idle cycle.
REQ-020 With tready=0 and tvalid=1, SHALL hold tdata and tlast stable and SHALL NOT pop.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, enter HDR and clear the byte counter, the remaining counter and any partial preamble; this applies from any state, including mid-frame.
REQ-022 While rst=1 and in the first cycle after, SHALL drive din_read, tx_ip_hdr_valid, tvalid, tlast and busy to 0, and every header field output to 0.
REQ-023 SHALL NOT resynchronise to a frame boundary after reset; upstream is reset on the same rst.

Configuration
REQ-024 With IP_TX_LEN_CHECK_EN defined, a frame with LEN=0 or LEN>MAX_PAYLOAD SHALL NOT be forwarded.
- The block goes to DRAIN instead of SEND_HDR.
- DRAIN pops LEN bytes at one per available byte, with no header and no payload beats.
- A 16-bit saturating output drop_count (out, 16, reset 0) increments once per dropped frame.
REQ-025 Without IP_TX_LEN_CHECK_EN:
- The drop_count port and the DRAIN state SHALL be absent.
- Every LEN SHALL be forwarded; LEN=0 yields a header with length 20 and no payload beats.

Verification
REQ-026 SHALL cover this scenario: preamble C0 A8 01 02 00 03 11 40, payload AA BB CC, local_ip C0A80164, ready held 1 -> one header (dest C0A80102, src C0A80164, length 23, proto 0x11, ttl 0x40), then beats AA BB CC with tlast only on CC.
REQ-027 SHALL cover this scenario: same frame with tx_ip_hdr_ready held 0 for 5 cycles -> valid held, fields stable, no din_read during those cycles.
REQ-028 SHALL cover this scenario: tready toggling 1/0 every cycle over a 4-byte payload -> exactly 4 pops, data order preserved, tlast on the 4th beat.
REQ-029 SHALL cover this scenario: two frames back-to-back in the FIFO -> the second preamble's first pop occurs in the cycle after the first frame's tlast.
REQ-030 SHALL cover this scenario: rst pulsed after 2 of 5 payload bytes -> all outputs 0 next cycle, state HDR, and a following fresh frame is forwarded correctly.
REQ-031 SHALL cover this scenario: with IP_TX_LEN_CHECK_EN, LEN=1481 followed by a valid frame -> 1481 bytes drained, drop_count=1, and only the valid frame appears on the outputs.
